// File: rtl/pipeline_stall_controller_pkg.sv
// Shared pipeline control definitions: FSM encodings, timeout default and
// the per-situation control vectors the stall controller selects between.
package pipeline_stall_controller_pkg;

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MD_BUSY = 1'b1;

    localparam int MD_TIMEOUT_DEFAULT = 64;
    localparam int CNT_W_DEFAULT      = 32;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_bubble;
        logic mem_wb_bubble;
        logic md_start;
        logic md_ack;
    } ctrl_t;

    // Field order: enables(4) | flushes/bubbles(4) | md_start, md_ack
    localparam ctrl_t CTRL_RESET    = 10'b0000_1111_00;
    localparam ctrl_t CTRL_MEM_WAIT = 10'b0000_0001_00;
    localparam ctrl_t CTRL_BRANCH   = 10'b1111_1100_00;
    localparam ctrl_t CTRL_LOAD_USE = 10'b0011_0100_00;
    localparam ctrl_t CTRL_MD_START = 10'b0001_0010_10;
    localparam ctrl_t CTRL_MD_WAIT  = 10'b0001_0010_00;
    localparam ctrl_t CTRL_MD_ACK   = 10'b1111_0000_01;
    localparam ctrl_t CTRL_IDLE     = 10'b1111_0000_00;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard inputs and stage-control outputs exchanged between the pipeline
// datapath and the stall controller.
interface pipeline_stall_controller_if;
    logic load_use_hazard;
    logic branch_taken;
    logic ex_md_valid;
    logic md_done;
    logic mem_req;
    logic mem_ready;
    logic md_start;
    logic md_ack;
    logic pc_we;
    logic if_id_we;
    logic id_ex_we;
    logic ex_mem_we;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_bubble;
    logic mem_wb_bubble;

    modport master (
        input  load_use_hazard, branch_taken, ex_md_valid, md_done, mem_req, mem_ready,
        output md_start, md_ack, pc_we, if_id_we, id_ex_we, ex_mem_we,
        output if_id_flush, id_ex_flush, ex_mem_bubble, mem_wb_bubble
    );

    modport slave (
        output load_use_hazard, branch_taken, ex_md_valid, md_done, mem_req, mem_ready,
        input  md_start, md_ack, pc_we, if_id_we, id_ex_we, ex_mem_we,
        input  if_id_flush, id_ex_flush, ex_mem_bubble, mem_wb_bubble
    );
endinterface

// File: rtl/pipeline_stall_controller_perf_counter.sv
// Free-running event counter with enable; wraps modulo 2^W.
module perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         en_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign count_o = cnt_q;
endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline hazard/stall controller: picks one control vector per cycle from
// memory wait, branch, MUL/DIV and load-use conditions; counts stalls/flushes.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    pipeline_stall_controller_if.master pipe,
    output logic [CNT_W-1:0]        stall_cycles,
    output logic [CNT_W-1:0]        flush_count,
    output logic                    md_error
);
    localparam int TMO_W = $clog2(MD_TIMEOUT + 1);

    logic [0:0]       state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             md_error_q, md_error_d;
    ctrl_t            ctrl;
    logic             mem_wait;
    logic             timeout_hit;

    assign mem_wait    = pipe.mem_req & ~pipe.mem_ready;
    // Fires on the MD_TIMEOUT-th busy cycle so the error is visible right after it
    assign timeout_hit = (tmo_q >= TMO_W'(MD_TIMEOUT - 1));

    always_comb begin
        ctrl       = CTRL_IDLE;
        state_d    = state_q;
        tmo_d      = tmo_q;
        md_error_d = md_error_q;
        if (state_q == ST_MD_BUSY && tmo_q != TMO_W'(MD_TIMEOUT)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        if (rst) begin
            ctrl = CTRL_RESET;
        end else if (mem_wait) begin
            ctrl = CTRL_MEM_WAIT;
        end else if (state_q == ST_RUN) begin
            if (pipe.branch_taken) begin
                ctrl = CTRL_BRANCH;
            end else if (pipe.ex_md_valid) begin
                ctrl    = CTRL_MD_START;
                state_d = ST_MD_BUSY;
                tmo_d   = '0;
            end else if (pipe.load_use_hazard) begin
                ctrl = CTRL_LOAD_USE;
            end
        end else begin
            if (pipe.md_done) begin
                ctrl    = CTRL_MD_ACK;
                state_d = ST_RUN;
            end else if (timeout_hit) begin
                ctrl       = CTRL_MD_ACK;
                state_d    = ST_RUN;
                md_error_d = 1'b1;
            end else begin
                ctrl = CTRL_MD_WAIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            tmo_q      <= '0;
            md_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            md_error_q <= md_error_d;
        end
    end

    assign pipe.pc_we         = ctrl.pc_we;
    assign pipe.if_id_we      = ctrl.if_id_we;
    assign pipe.id_ex_we      = ctrl.id_ex_we;
    assign pipe.ex_mem_we     = ctrl.ex_mem_we;
    assign pipe.if_id_flush   = ctrl.if_id_flush;
    assign pipe.id_ex_flush   = ctrl.id_ex_flush;
    assign pipe.ex_mem_bubble = ctrl.ex_mem_bubble;
    assign pipe.mem_wb_bubble = ctrl.mem_wb_bubble;
    assign pipe.md_start      = ctrl.md_start;
    assign pipe.md_ack        = ctrl.md_ack;
    assign md_error           = md_error_q;

    perf_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .srst    (rst),
        .en_i    (~ctrl.pc_we),
        .count_o (stall_cycles)
    );

    perf_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .srst    (rst),
        .en_i    (ctrl.if_id_flush),
        .count_o (flush_count)
    );
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: behavioural model checked every cycle
// plus directed scenarios with literal expectations.
module tb_pipeline_stall_controller;
    localparam int TMO = 8;

    // Expected control patterns:
    // {pc_we,if_id_we,id_ex_we,ex_mem_we,if_id_flush,id_ex_flush,ex_mem_bubble,mem_wb_bubble,md_start,md_ack}
    localparam logic [9:0] P_RESET = 10'b0000111100;
    localparam logic [9:0] P_MEMW  = 10'b0000000100;
    localparam logic [9:0] P_BR    = 10'b1111110000;
    localparam logic [9:0] P_LU    = 10'b0011010000;
    localparam logic [9:0] P_MDS   = 10'b0001001010;
    localparam logic [9:0] P_MDW   = 10'b0001001000;
    localparam logic [9:0] P_ACK   = 10'b1111000001;
    localparam logic [9:0] P_IDLE  = 10'b1111000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
    logic        md_error;
    int          errors = 0;
    int          checks = 0;

    pipeline_stall_controller_if pif();

    pipeline_stall_controller #(.MD_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe         (pif),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count),
        .md_error     (md_error)
    );

    always #5 clk = ~clk;

    wire [9:0] vec = {pif.pc_we, pif.if_id_we, pif.id_ex_we, pif.ex_mem_we,
                      pif.if_id_flush, pif.id_ex_flush, pif.ex_mem_bubble,
                      pif.mem_wb_bubble, pif.md_start, pif.md_ack};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: is a MUL/DIV op outstanding, how many busy cycles elapsed, counters
    bit m_busy = 0;
    bit m_err = 0;
    int m_busy_n = 0;
    int m_stall = 0;
    int m_flush = 0;

    always @(negedge clk) begin
        logic [9:0] exp;
        if (rst)
            exp = P_RESET;
        else if (pif.mem_req && !pif.mem_ready)
            exp = P_MEMW;
        else if (!m_busy)
            exp = pif.branch_taken ? P_BR : pif.ex_md_valid ? P_MDS :
                  pif.load_use_hazard ? P_LU : P_IDLE;
        else
            exp = (pif.md_done || (m_busy_n + 1 >= TMO)) ? P_ACK : P_MDW;

        chk("model_ctrl", 32'(vec), 32'(exp));
        chk("model_stall_cycles", stall_cycles, 32'(m_stall));
        chk("model_flush_count", flush_count, 32'(m_flush));
        chk("model_md_error", 32'(md_error), 32'(m_err));

        if (rst) begin
            m_busy = 0; m_err = 0; m_busy_n = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (m_busy && m_busy_n < TMO) m_busy_n++;
            if (exp == P_MDS) begin m_busy = 1; m_busy_n = 0; end
            if (exp == P_ACK) begin m_busy = 0; if (!pif.md_done) m_err = 1; end
            if (!exp[9]) m_stall++;
            if (exp[5]) m_flush++;
        end
    end

    // in = {load_use_hazard, branch_taken, ex_md_valid, md_done, mem_req, mem_ready}
    task automatic step(input logic r, input logic [5:0] in);
        @(posedge clk);
        #1;
        rst = r;
        {pif.load_use_hazard, pif.branch_taken, pif.ex_md_valid,
         pif.md_done, pif.mem_req, pif.mem_ready} = in;
        @(negedge clk);
        #1;
    endtask

    initial begin
        {pif.load_use_hazard, pif.branch_taken, pif.ex_md_valid,
         pif.md_done, pif.mem_req, pif.mem_ready} = 6'b0;

        repeat (3) step(1'b1, 6'b0);
        chk("reset_ctrl", 32'(vec), 32'(P_RESET));
        step(1'b0, 6'b0);
        chk("idle_after_reset", 32'(vec), 32'(P_IDLE));
        chk("stall_after_reset", stall_cycles, 0);
        chk("flush_after_reset", flush_count, 0);

        step(1'b0, 6'b100000);
        chk("lu_pc_we", 32'(pif.pc_we), 0);
        chk("lu_id_ex_flush", 32'(pif.id_ex_flush), 1);
        step(1'b0, 6'b0);
        chk("lu_stall_count", stall_cycles, 1);

        step(1'b1, 6'b0);
        step(1'b0, 6'b0);
        step(1'b0, 6'b110000);
        chk("br_lu_ctrl", 32'(vec), 32'(P_BR));
        step(1'b0, 6'b0);
        chk("br_flush_count", flush_count, 1);
        chk("br_stall_count", stall_cycles, 0);

        step(1'b1, 6'b0);
        step(1'b0, 6'b0);
        step(1'b0, 6'b001000);
        chk("md_start_pulse", 32'(pif.md_start), 1);
        chk("md_start_frozen", 32'(pif.pc_we), 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 6'b001000);
            chk("md_busy_frozen", 32'(pif.pc_we), 0);
            chk("md_busy_no_start", 32'(pif.md_start), 0);
            chk("md_busy_no_ack", 32'(pif.md_ack), 0);
        end
        step(1'b0, 6'b001100);
        chk("md_ack_6th", 32'(vec), 32'(P_ACK));
        step(1'b0, 6'b0);
        chk("md_stall_count", stall_cycles, 5);
        chk("md_after_ack_idle", 32'(vec), 32'(P_IDLE));

        step(1'b1, 6'b0);
        step(1'b0, 6'b0);
        step(1'b0, 6'b001000);
        step(1'b0, 6'b001000);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 6'b001110);
            chk("memwait_no_ack", 32'(pif.md_ack), 0);
            chk("memwait_bubble", 32'(vec), 32'(P_MEMW));
        end
        step(1'b0, 6'b001101);
        chk("memwait_ack_4th", 32'(pif.md_ack), 1);
        step(1'b0, 6'b0);

        step(1'b1, 6'b0);
        step(1'b0, 6'b0);
        step(1'b0, 6'b001000);
        for (int i = 1; i <= TMO; i++) begin
            step(1'b0, 6'b001000);
            chk("tmo_ack", 32'(pif.md_ack), (i == TMO) ? 1 : 0);
            chk("tmo_no_err_yet", 32'(md_error), 0);
        end
        step(1'b0, 6'b0);
        chk("tmo_error_set", 32'(md_error), 1);
        chk("tmo_back_to_run", 32'(vec), 32'(P_IDLE));
        repeat (3) step(1'b0, 6'b0);
        chk("tmo_error_sticky", 32'(md_error), 1);
        step(1'b0, 6'b001000);
        step(1'b0, 6'b001000);
        step(1'b1, 6'b001000);
        step(1'b0, 6'b0);
        chk("rst_clears_error", 32'(md_error), 0);
        chk("rst_mid_busy_run", 32'(vec), 32'(P_IDLE));
        step(1'b0, 6'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 64, max MD_BUSY cycles before md_error sets.
REQ-002 SHALL have parameter CNT_W, default 32, width of the performance counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port load_use_hazard  input  1  stall request from the load-use detector (ID needs a load result still in EX).
REQ-006 SHALL have port branch_taken  input  1  EX resolved a taken branch or jump this cycle.
REQ-007 SHALL have port ex_md_valid  input  1  EX holds a multi-cycle MUL/DIV op.
REQ-008 SHALL have port md_done  input  1  MUL/DIV result valid; level, held until md_ack.
REQ-009 SHALL have port mem_req / mem_ready  input  1 each  MEM-stage data access pending / completing.
REQ-010 SHALL have port md_start / md_ack  output  1 each  single-cycle pulses to the MUL/DIV unit.
REQ-011 SHALL have port pc_we, if_id_we, id_ex_we, ex_mem_we  output  1 each  stage-register write enables.
REQ-012 SHALL have port if_id_flush, id_ex_flush, ex_mem_bubble, mem_wb_bubble  output  1 each  insert NOP into that register.
REQ-013 SHALL have port stall_cycles, flush_count  output  CNT_W each  performance counters; md_error  output  1  sticky timeout flag.

Function
REQ-014 SHALL implement FSM states RUN, MD_BUSY; outputs are combinational from state and inputs (same-cycle stall).
REQ-015 Memory wait (mem_req & !mem_ready) SHALL have top priority in any state: all four write enables 0, mem_wb_bubble 1, all flushes 0, md_start/md_ack 0, state held.
REQ-016 In RUN without memory wait, branch_taken SHALL assert if_id_flush and id_ex_flush with pc_we 1; a coincident load_use_hazard is ignored.
REQ-017 In RUN, load_use_hazard without branch_taken SHALL give pc_we 0, if_id_we 0, id_ex_flush 1, ex_mem_we 1 (one bubble per asserted cycle).
REQ-018 In RUN, ex_md_valid without memory wait SHALL pulse md_start, freeze PC/IF/ID/ID/EX (enables 0), assert ex_mem_bubble, and go to MD_BUSY next cycle; it takes priority over load_use_hazard.
REQ-019 In MD_BUSY with md_done=0, outputs SHALL match REQ-018 except md_start 0.
REQ-020 In MD_BUSY with md_done=1 and no memory wait, all enables SHALL be 1, ex_mem_bubble 0, md_ack 1, next state RUN.
REQ-021 With no hazard in RUN, all enables SHALL be 1 and all flush/bubble/pulse outputs 0.
REQ-022 A timeout counter SHALL clear on MD_BUSY entry and increment each MD_BUSY cycle; reaching MD_TIMEOUT sets md_error and forces RUN, with md_ack pulsed once.
REQ-023 stall_cycles SHALL increment by 1 in any cycle with pc_we=0; flush_count SHALL increment by 1 in any cycle with if_id_flush=1; both wrap modulo 2^CNT_W.

Reset
REQ-024 While rst=1, all write enables SHALL be 0, if_id_flush/id_ex_flush/ex_mem_bubble/mem_wb_bubble 1, md_start/md_ack 0.
REQ-025 On a clk edge with rst=1, state SHALL become RUN, counters and timeout counter 0, and md_error 0, including mid MD_BUSY.
REQ-026 On the first cycle after rst falls, the block SHALL behave per REQ-021 when inputs are idle.

Structure
REQ-027 FSM state encodings and default MD_TIMEOUT SHALL live in the shared core package with the pipeline control constants.
REQ-028 Performance counters SHALL be one sub-module, perf_counter (enable, wrap), instantiated twice.

Verification
REQ-029 Reset with rst high for 3 cycles -> enables 0, flushes 1; after release, idle inputs give all enables 1, counters 0.
REQ-030 load_use_hazard=1 for 1 cycle -> pc_we=0, id_ex_flush=1 that cycle; stall_cycles=1.
REQ-031 branch_taken=1 and load_use_hazard=1 together -> if_id_flush=id_ex_flush=1, pc_we=1; flush_count=1, stall_cycles unchanged.
REQ-032 ex_md_valid=1, md_done raised 5 cycles after md_start -> 1 md_start pulse, 5 frozen cycles, md_ack on the 6th, stall_cycles=5.
REQ-033 In MD_BUSY with md_done=1 and mem_req=1, mem_ready=0 for 3 cycles -> no md_ack for 3 cycles, md_ack on the 4th.
REQ-034 MD_TIMEOUT=8, md_done never set -> md_error=1 after 8 MD_BUSY cycles, state RUN, md_error sticky until rst.
